instr_fetch_queue: RTL and testbench

- Instruction-fetch front end that drives the PC register's next-value path. It holds the fetch PC, issues in-order read requests to instruction memory, and buffers the returned instruction words.
- Delivers {pc, instr} pairs to the IF/ID stage over a valid/ready handshake.
- Handles branch/jump redirects by flushing queued and in-flight fetches.

---
 rtl/instr_fetch_queue.sv | 115 +++++++++++
 tb/tb_instr_fetch_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem reads,
// and buffers returned words as {pc, instr} entries for the decode stage.
module instr_fetch_queue #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic              rst_q;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [PTR_W-1:0]  tag_wr;
    logic [PTR_W-1:0]  tag_rd;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] tag_mem   [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];

    logic [SUM_W-1:0]  in_flight;
    logic              req_fire;
    logic              rsp_keep;
    logic              id_pop;

    // Credit: every issued request is guaranteed a data-queue slot on return.
    always_comb begin
        in_flight      = {1'b0, outstanding} + {1'b0, count};
        imem_req_valid = !rst_q && !redirect_valid
                         && (in_flight < SUM_W'(DEPTH))
                         && (drop_cnt == '0);
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
        id_pop         = id_valid && id_ready;
    end

    assign imem_req_addr = fetch_pc;
    assign id_valid      = (count != '0);
    assign id_pc         = pc_mem[rd_ptr];
    assign id_instr      = instr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_mem[i]   <= '0;
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            // Tag FIFO tracks the PC of every outstanding request, dropped or not.
            if (req_fire) begin
                tag_mem[tag_wr] <= fetch_pc;
                tag_wr          <= tag_wr + PTR_W'(1);
            end
            if (imem_rsp_valid) begin
                tag_rd <= tag_rd + PTR_W'(1);
            end
            if (rsp_keep) begin
                pc_mem[wr_ptr]    <= tag_mem[tag_rd];
                instr_mem[wr_ptr] <= imem_rsp_data;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                fetch_pc <= redirect_pc;
                count    <= '0;
                rd_ptr   <= wr_ptr;
                drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                count <= count + CNT_W'(rsp_keep) - CNT_W'(id_pop);
                if (id_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, scripted corner cases,
// and randomized traffic checked against a queue-based reference model.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    instr_fetch_queue #(
        .DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int lat      = 1;
    bit armed    = 0;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] pc; bit stale; } tag_t;

    mreq_t       mem_q[$];
    ent_t        m_q[$];
    tag_t        m_out[$];
    logic [31:0] m_pc;
    bit          m_rstq;

    logic [31:0] obs_fire[$];
    logic [31:0] obs_pop[$];
    bit          last_req_v, last_id_v, last_pop;

    typedef struct {
        bit req_rdy; bit rsp_v; logic [31:0] rsp_d; bit redir; logic [31:0] rpc; bit id_rdy;
        bit e_req_v; logic [31:0] e_addr; bit e_id_v; logic [31:0] e_pc; logic [31:0] e_instr;
    } vec_t;
    vec_t vecs[14];

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
    endtask

    // One clock of memory model + reference model; DUT sampled at negedge+1.
    task automatic run_cycle(input bit do_rst, input bit rdy_req, input bit rdy_id,
                             input bit redir, input logic [31:0] rpc);
        bit   e_req_v, fire, pop, rsp, any_stale;
        tag_t t;
        @(negedge clk);
        rst            = do_rst;
        imem_req_ready = rdy_req;
        id_ready       = rdy_id;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp            = !do_rst && (mem_q.size() != 0) && (mem_q[0].due <= cyc + 1);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? word(mem_q[0].addr) : $urandom;
        #1;
        any_stale = 0;
        foreach (m_out[i]) if (m_out[i].stale) any_stale = 1;
        e_req_v = !m_rstq && !redir && (m_out.size() + m_q.size() < DEPTH) && !any_stale;
        if (armed) begin
            check("req_valid", imem_req_valid, e_req_v);
            check("req_addr", imem_req_addr, m_pc);
            check("id_valid", id_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                check("id_pc", id_pc, m_q[0].pc);
                check("id_instr", id_instr, m_q[0].instr);
            end else if (m_rstq) begin
                check("reset id_pc", id_pc, 0);
                check("reset id_instr", id_instr, 0);
            end
        end
        last_req_v = imem_req_valid;
        last_id_v  = id_valid;
        last_pop   = id_valid && id_ready;
        if (imem_req_valid && imem_req_ready) obs_fire.push_back(imem_req_addr);
        if (id_valid && id_ready) obs_pop.push_back(id_pc);
        fire = e_req_v && rdy_req;
        pop  = (m_q.size() != 0) && rdy_id;
        @(posedge clk);
        cyc++;
        if (do_rst) begin
            m_q.delete(); m_out.delete(); mem_q.delete();
            m_pc = RESET_PC; m_rstq = 1; armed = 1;
        end else begin
            m_rstq = 0;
            if (fire) begin
                mem_q.push_back('{m_pc, cyc + lat});
                m_out.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (pop) void'(m_q.pop_front());
            if (rsp) begin
                void'(mem_q.pop_front());
                t = m_out.pop_front();
                if (!t.stale && !redir) m_q.push_back('{t.pc, word(t.pc)});
            end
            if (redir) begin
                m_q.delete();
                foreach (m_out[i]) m_out[i].stale = 1;
                m_pc = rpc;
            end
        end
    endtask

    task automatic do_reset();
        run_cycle(1, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0);
        check("reset req_valid", last_req_v, 0);
        check("reset id_valid", last_id_v, 0);
    endtask

    task automatic apply_vec(input int k, input vec_t v);
        @(negedge clk);
        rst            = 0;
        imem_req_ready = v.req_rdy;
        imem_rsp_valid = v.rsp_v;
        imem_rsp_data  = v.rsp_d;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        id_ready       = v.id_rdy;
        #1;
        check($sformatf("vec%0d req_valid", k), imem_req_valid, v.e_req_v);
        check($sformatf("vec%0d req_addr", k), imem_req_addr, v.e_addr);
        check($sformatf("vec%0d id_valid", k), id_valid, v.e_id_v);
        if (v.e_id_v) begin
            check($sformatf("vec%0d id_pc", k), id_pc, v.e_pc);
            check($sformatf("vec%0d id_instr", k), id_instr, v.e_instr);
        end
        @(posedge clk);
        cyc++;
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        logic [31:0] rpc;
        bit          rr, rd, rx, rs;
        rst = 1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; id_ready = 0;

        // req_rdy rsp_v rsp_d redir rpc id_rdy | req_v addr id_v pc instr
        vecs[0]  = '{1, 0, 32'h0,    0, 32'h0,   0, 1, 32'h000, 0, 32'h0,   32'h0};
        vecs[1]  = '{1, 1, 32'hAAA0, 0, 32'h0,   0, 1, 32'h004, 0, 32'h0,   32'h0};
        vecs[2]  = '{0, 1, 32'hAAA4, 0, 32'h0,   0, 1, 32'h008, 1, 32'h0,   32'hAAA0};
        vecs[3]  = '{1, 0, 32'h0,    0, 32'h0,   1, 1, 32'h008, 1, 32'h0,   32'hAAA0};
        vecs[4]  = '{1, 0, 32'h0,    0, 32'h0,   0, 1, 32'h00C, 1, 32'h4,   32'hAAA4};
        vecs[5]  = '{1, 1, 32'hBBB8, 1, 32'h100, 1, 0, 32'h010, 1, 32'h4,   32'hAAA4};
        vecs[6]  = '{1, 0, 32'h0,    0, 32'h0,   1, 0, 32'h100, 0, 32'h0,   32'h0};
        vecs[7]  = '{1, 1, 32'hBBBC, 0, 32'h0,   0, 0, 32'h100, 0, 32'h0,   32'h0};
        vecs[8]  = '{1, 0, 32'h0,    0, 32'h0,   0, 1, 32'h100, 0, 32'h0,   32'h0};
        vecs[9]  = '{0, 1, 32'hC100, 0, 32'h0,   0, 1, 32'h104, 0, 32'h0,   32'h0};
        vecs[10] = '{0, 0, 32'h0,    0, 32'h0,   0, 1, 32'h104, 1, 32'h100, 32'hC100};
        vecs[11] = '{0, 0, 32'h0,    1, 32'h203, 0, 0, 32'h104, 1, 32'h100, 32'hC100};
        vecs[12] = '{1, 0, 32'h0,    0, 32'h0,   0, 1, 32'h203, 0, 32'h0,   32'h0};
        vecs[13] = '{0, 0, 32'h0,    0, 32'h0,   0, 1, 32'h207, 0, 32'h0,   32'h0};

        // Directed vector table straight after reset.
        do_reset();
        run_cycle(0, 0, 0, 0, 0);
        armed = 0;
        for (int k = 0; k < 14; k++) apply_vec(k, vecs[k]);

        // Streaming, 1-cycle memory: first pop 3 cycles after release, then 1/cycle.
        do_reset();
        lat = 1; obs_pop.delete();
        repeat (20) run_cycle(0, 1, 1, 0, 0);
        check("stream pop count", 64'(obs_pop.size()), 17);
        check("stream first pc", qat(obs_pop, 0), 32'h0);
        check("stream last pc", qat(obs_pop, 16), 32'h40);

        // Decode stalled: exactly DEPTH requests, then drain and resume at 0x10.
        do_reset();
        obs_fire.delete(); obs_pop.delete();
        repeat (15) run_cycle(0, 1, 0, 0, 0);
        check("stall fire count", 64'(obs_fire.size()), 4);
        check("stall req_valid", last_req_v, 0);
        repeat (10) run_cycle(0, 1, 1, 0, 0);
        check("drain pc0", qat(obs_pop, 0), 32'h0);
        check("drain pc1", qat(obs_pop, 1), 32'h4);
        check("drain pc2", qat(obs_pop, 2), 32'h8);
        check("drain pc3", qat(obs_pop, 3), 32'hC);
        check("resume addr", qat(obs_fire, 4), 32'h10);

        // 3-cycle memory, redirect with two requests in flight.
        do_reset();
        lat = 3; obs_fire.delete();
        repeat (3) run_cycle(0, 1, 1, 0, 0);
        check("pre-redirect fires", 64'(obs_fire.size()), 2);
        run_cycle(0, 1, 1, 1, 32'h100);
        obs_fire.delete(); obs_pop.delete();
        repeat (12) run_cycle(0, 1, 1, 0, 0);
        check("redirect first addr", qat(obs_fire, 0), 32'h100);
        check("redirect first id_pc", qat(obs_pop, 0), 32'h100);

        // Redirect colliding with a response and a decode handshake; target wraps.
        do_reset();
        lat = 2;
        repeat (10) run_cycle(0, 1, 1, 0, 0);
        run_cycle(0, 1, 1, 1, 32'hFFFF_FFF8);
        check("redirect-cycle pop", last_pop, 1);
        run_cycle(0, 1, 1, 0, 0);
        check("post-redirect id_valid", last_id_v, 0);
        check("post-redirect drop hold", last_req_v, 0);
        obs_fire.delete(); obs_pop.delete();
        repeat (10) run_cycle(0, 1, 1, 0, 0);
        check("wrap addr0", qat(obs_fire, 0), 32'hFFFF_FFF8);
        check("wrap addr1", qat(obs_fire, 1), 32'hFFFF_FFFC);
        check("wrap addr2", qat(obs_fire, 2), 32'h0);
        check("wrap first id_pc", qat(obs_pop, 0), 32'hFFFF_FFF8);

        // Reset with a full queue.
        do_reset();
        lat = 1;
        repeat (10) run_cycle(0, 1, 0, 0, 0);
        check("full id_valid", last_id_v, 1);
        run_cycle(1, 1, 0, 0, 0);
        run_cycle(0, 1, 1, 0, 0);
        check("mid-reset req_valid", last_req_v, 0);
        check("mid-reset id_valid", last_id_v, 0);
        obs_fire.delete();
        repeat (5) run_cycle(0, 1, 1, 0, 0);
        check("mid-reset first addr", qat(obs_fire, 0), RESET_PC);

        // Randomized traffic against the reference model.
        for (int ph = 0; ph < 4; ph++) begin
            lat = 1 + (ph % 3);
            repeat (500) begin
                rr = ($urandom_range(99) < 70);
                rd = ($urandom_range(99) < 60);
                rx = ($urandom_range(99) < 4);
                rs = ($urandom_range(399) == 0);
                case ($urandom_range(2))
                    0:       rpc = $urandom & 32'hFFFF_FFFC;
                    1:       rpc = 32'hFFFF_FFF0;
                    default: rpc = $urandom;
                endcase
                run_cycle(rs, rr, rd, rx, rpc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
